// File: rtl/alu_pkg.sv
// Shared opcode, state and helper definitions for the alu_seq block.
// ALU_DIV_EN selects whether DIVU/REMU are legal iterative ops.
package alu_pkg;

  localparam logic [3:0] OP_AND   = 4'd0;
  localparam logic [3:0] OP_OR    = 4'd1;
  localparam logic [3:0] OP_XOR   = 4'd2;
  localparam logic [3:0] OP_XNOR  = 4'd3;
  localparam logic [3:0] OP_ADD   = 4'd4;
  localparam logic [3:0] OP_SUB   = 4'd5;
  localparam logic [3:0] OP_SLTU  = 4'd6;
  localparam logic [3:0] OP_SLL   = 4'd7;
  localparam logic [3:0] OP_SLT   = 4'd8;
  localparam logic [3:0] OP_SRL   = 4'd9;
  localparam logic [3:0] OP_SRA   = 4'd10;
  localparam logic [3:0] OP_MUL   = 4'd11;
  localparam logic [3:0] OP_MULHU = 4'd12;
  localparam logic [3:0] OP_DIVU  = 4'd13;
  localparam logic [3:0] OP_REMU  = 4'd14;
  localparam logic [3:0] OP_RSVD  = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_iterative(input logic [3:0] op);
`ifdef ALU_DIV_EN
    return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
`else
    return (op == OP_MUL) || (op == OP_MULHU);
`endif
  endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// WIDTH-step shift-add multiplier; with ALU_DIV_EN also a restoring divider.
// hi_o/lo_o expose the post-step value so the caller can capture on last_o.
module alu_iter_muldiv #(
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             last_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opd_q, opd_d;
  logic [WIDTH:0]   mstep;

`ifdef ALU_DIV_EN
  logic             div_q, div_d;
  logic [WIDTH:0]   rpart, rtrial;
`else
  logic             unused_div;
  assign unused_div = div_i;
`endif

  always_comb begin
    cnt_d = cnt_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    opd_d = opd_q;
    mstep = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
`ifdef ALU_DIV_EN
    div_d  = div_q;
    rpart  = {hi_q, lo_q[WIDTH-1]};
    rtrial = rpart - {1'b0, opd_q};
`endif
    if (start_i) begin
      cnt_d = CW'(WIDTH);
      hi_d  = '0;
`ifdef ALU_DIV_EN
      div_d = div_i;
      lo_d  = div_i ? a_i : b_i;
      opd_d = div_i ? b_i : a_i;
`else
      lo_d  = b_i;
      opd_d = a_i;
`endif
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
`ifdef ALU_DIV_EN
      // Remainder shifts into hi, quotient bits shift into lo as dividend leaves.
      if (div_q) begin
        if (!rtrial[WIDTH]) begin
          hi_d = rtrial[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          hi_d = rpart[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b0};
        end
      end else
`endif
      begin
        hi_d = mstep[WIDTH:1];
        lo_d = {mstep[0], lo_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      opd_q <= '0;
`ifdef ALU_DIV_EN
      div_q <= 1'b0;
`endif
    end else begin
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      opd_q <= opd_d;
`ifdef ALU_DIV_EN
      div_q <= div_d;
`endif
    end
  end

  assign last_o = (cnt_q == CW'(1));
  assign hi_o   = hi_d;
  assign lo_o   = lo_d;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes and an iterative mul (div under ALU_DIV_EN).
// Single-cycle ops land in DONE one edge after accept; iterative ops take 1+WIDTH.
module alu_seq
  import alu_pkg::*;
#(
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             zf,
  output logic             sf,
  output logic             cf,
  output logic             of,
  output logic             err
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic             zf_q, zf_d, cf_q, cf_d, of_q, of_d, err_q, err_d;
  logic [3:0]       op_q, op_d;

  logic             accept, iter_op, eng_start, eng_last;
  logic [WIDTH-1:0] eng_hi, eng_lo, iter_f;
  logic [WIDTH-1:0] sc_f;
  logic             sc_cf, sc_of, sc_err;
  logic [WIDTH:0]   sum;
  logic [SHW-1:0]   shamt;

  assign accept  = in_valid & in_ready;
  assign iter_op = is_iterative(alu_op);
  assign shamt   = a[SHW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = iter_op ? ST_BUSY : ST_DONE;
      ST_BUSY: if (eng_last) state_d = ST_DONE;
      ST_DONE: begin
        if (out_ready) begin
          if (accept) state_d = iter_op ? ST_BUSY : ST_DONE;
          else        state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
    out_valid = (state_q == ST_DONE);
    eng_start = accept & iter_op;
  end

  alu_iter_muldiv #(.WIDTH(WIDTH)) u_iter (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (eng_start),
    .div_i   ((alu_op == OP_DIVU) || (alu_op == OP_REMU)),
    .a_i     (a),
    .b_i     (b),
    .last_o  (eng_last),
    .hi_o    (eng_hi),
    .lo_o    (eng_lo)
  );

  always_comb begin
    sc_f   = '0;
    sc_cf  = 1'b0;
    sc_of  = 1'b0;
    sc_err = 1'b0;
    sum    = '0;
    case (alu_op)
      OP_AND:  sc_f = a & b;
      OP_OR:   sc_f = a | b;
      OP_XOR:  sc_f = a ^ b;
      OP_XNOR: sc_f = ~(a ^ b);
      OP_ADD: begin
        sum   = {1'b0, a} + {1'b0, b};
        sc_f  = sum[WIDTH-1:0];
        sc_cf = sum[WIDTH];
        sc_of = (a[WIDTH-1] == b[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        // Bit WIDTH of the widened difference is the unsigned borrow (a < b).
        sum   = {1'b0, a} - {1'b0, b};
        sc_f  = sum[WIDTH-1:0];
        sc_cf = sum[WIDTH];
        sc_of = (a[WIDTH-1] != b[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLTU: sc_f = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLT:  sc_f = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL:  sc_f = b << shamt;
      OP_SRL:  sc_f = b >> shamt;
      OP_SRA:  sc_f = $unsigned($signed(b) >>> shamt);
      default: sc_err = 1'b1;
    endcase
  end

  always_comb begin
    case (op_q)
      OP_MULHU, OP_REMU: iter_f = eng_hi;
      default:           iter_f = eng_lo;
    endcase
  end

  always_comb begin
    f_d   = f_q;
    zf_d  = zf_q;
    cf_d  = cf_q;
    of_d  = of_q;
    err_d = err_q;
    op_d  = op_q;
    if (accept) begin
      if (iter_op) begin
        op_d = alu_op;
      end else begin
        f_d   = sc_f;
        zf_d  = (sc_f == '0);
        cf_d  = sc_cf;
        of_d  = sc_of;
        err_d = sc_err;
      end
    end else if ((state_q == ST_BUSY) && eng_last) begin
      f_d   = iter_f;
      zf_d  = (iter_f == '0);
      cf_d  = 1'b0;
      of_d  = 1'b0;
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_q   <= '0;
      zf_q  <= 1'b0;
      cf_q  <= 1'b0;
      of_q  <= 1'b0;
      err_q <= 1'b0;
      op_q  <= OP_AND;
    end else begin
      f_q   <= f_d;
      zf_q  <= zf_d;
      cf_q  <= cf_d;
      of_q  <= of_d;
      err_q <= err_d;
      op_q  <= op_d;
    end
  end

  assign f   = f_q;
  assign zf  = zf_q;
  assign sf  = f_q[WIDTH-1];
  assign cf  = cf_q;
  assign of  = of_q;
  assign err = err_q;

endmodule
